// File: rtl/peripheral_io_bridge.sv
// Core-side command/response bridge with a log-sink output FIFO, a sticky
// overflow flag and a free-running 32-bit cycle counter.
module peripheral_io_bridge #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            to_peripheral,
   input  logic [DATA_WIDTH-1:0] to_peripheral_data,
   input  logic                  to_peripheral_valid,
   output logic [1:0]            from_peripheral,
   output logic [DATA_WIDTH-1:0] from_peripheral_data,
   output logic                  from_peripheral_valid,
   output logic [DATA_WIDTH-1:0] sink_data,
   output logic                  sink_valid,
   input  logic                  sink_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int XW = (DATA_WIDTH > 32) ? DATA_WIDTH : 32;
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [1:0] CMD_WRITE       = 2'b01;
   localparam logic [1:0] CMD_READ_STATUS = 2'b10;
   localparam logic [1:0] CMD_READ_CYCLES = 2'b11;

   localparam logic [1:0] RSP_NONE      = 2'b00;
   localparam logic [1:0] RSP_WRITE_ACK = 2'b01;
   localparam logic [1:0] RSP_DATA      = 2'b10;
   localparam logic [1:0] RSP_WRITE_ERR = 2'b11;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  overflow;
   logic [31:0]           cycle_cnt;

   logic                  is_empty;
   logic                  is_full;
   logic                  do_write;
   logic                  do_push;
   logic                  do_pop;
   logic [XW-1:0]         status_word;
   logic [XW-1:0]         cycles_word;

   assign is_empty = (count == '0);
   assign is_full  = (count == DEPTH_C);
   assign do_write = to_peripheral_valid && (to_peripheral == CMD_WRITE);
   // Fullness is judged on the pre-edge count, so a same-edge pop never frees room.
   assign do_push  = do_write && !is_full;
   assign do_pop   = !is_empty && sink_ready;

   assign sink_valid = !is_empty;
   assign sink_data  = is_empty ? '0 : mem[rd_ptr];

   always_comb begin
      status_word       = '0;
      status_word[0]    = is_empty;
      status_word[1]    = is_full;
      status_word[2]    = overflow;
      status_word[15:8] = 8'(count);
   end

   assign cycles_word = XW'(cycle_cnt);

   always_ff @(posedge clock) begin
      if (do_push) begin
         mem[wr_ptr] <= to_peripheral_data;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr                <= '0;
         rd_ptr                <= '0;
         count                 <= '0;
         overflow              <= 1'b0;
         cycle_cnt             <= '0;
         from_peripheral       <= RSP_NONE;
         from_peripheral_data  <= '0;
         from_peripheral_valid <= 1'b0;
      end else begin
         cycle_cnt             <= cycle_cnt + 32'd1;
         from_peripheral       <= RSP_NONE;
         from_peripheral_data  <= '0;
         from_peripheral_valid <= 1'b0;

         if (do_push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase

         if (to_peripheral_valid) begin
            case (to_peripheral)
               CMD_WRITE: begin
                  from_peripheral_valid <= 1'b1;
                  if (is_full) begin
                     from_peripheral <= RSP_WRITE_ERR;
                     overflow        <= 1'b1;
                  end else begin
                     from_peripheral <= RSP_WRITE_ACK;
                  end
               end
               CMD_READ_STATUS: begin
                  from_peripheral_valid <= 1'b1;
                  from_peripheral       <= RSP_DATA;
                  from_peripheral_data  <= status_word[DATA_WIDTH-1:0];
                  overflow              <= 1'b0;
               end
               CMD_READ_CYCLES: begin
                  from_peripheral_valid <= 1'b1;
                  from_peripheral       <= RSP_DATA;
                  from_peripheral_data  <= cycles_word[DATA_WIDTH-1:0];
               end
               default: ;
            endcase
         end
      end
   end

endmodule
